// File: rtl/seq_det_pkg.sv
// Shared definitions for the word-level scheduler of the serial 1011 detector:
// FSM encodings, the detected pattern and the result-counter width helper.
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    localparam logic [3:0] SEQ_PATTERN = 4'b1011;

    // Width able to hold every count from 0 up to and including length.
    function automatic int cnt_width(input int length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/seq_det_piso.sv
// Parallel-in serial-out register: loads a word, shifts it left so the MSB
// leaves first, and counts the bits already handed to the detector.
module seq_det_piso #(
    parameter int  LENGTH = 32,
    localparam int BC_W   = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LENGTH-1:0] load_data,
    input  logic              shift_en,
    input  logic              cnt_en,
    output logic              msb,
    output logic [BC_W-1:0]   bit_cnt
);

    logic [LENGTH-1:0] sr_reg;
    logic [LENGTH-1:0] sr_shift;
    logic [BC_W-1:0]   bit_cnt_reg;

    // Zero fill at the LSB so the register drains to all-zero after a word.
    assign sr_shift[0] = 1'b0;

    genvar gi;
    for (gi = 1; gi < LENGTH; gi++) begin : g_shift
        assign sr_shift[gi] = sr_reg[gi-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
        end else begin
            if (load) begin
                sr_reg <= load_data;
            end else if (shift_en) begin
                sr_reg <= sr_shift;
            end

            if (load) begin
                bit_cnt_reg <= '0;
            end else if (cnt_en) begin
                bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
            end
        end
    end

    assign msb     = sr_reg[LENGTH-1];
    assign bit_cnt = bit_cnt_reg;

endmodule

// File: rtl/seq_det_sched.sv
// Word scheduler: clears the detector, streams one word into it MSB-first,
// counts the matches belonging to that word and hands back the count.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int  LENGTH    = 32,
    parameter bit  MEALY_FSM = 1'b0,
    localparam int CNT_W     = cnt_width(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in_data,
    output logic              det_rst_n,
    output logic              det_stream,
    input  logic              det_match,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_hit
);

    localparam int              BC_W     = $clog2(LENGTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(LENGTH - 1);

    sched_state_t     state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             out_hit_reg;
    logic             det_rst_n_reg;
    logic             det_stream_reg;
    logic             prev_shift_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] out_count_reg;

    logic             accept;
    logic             sample_en;
    logic             piso_msb;
    logic [BC_W-1:0]  bit_cnt;

    assign accept = (state_reg == IDLE) && in_valid && in_ready_reg;

    // A Moore detector shows the match one cycle after the bit that caused it,
    // so its sampling window trails SHIFT by one cycle (ending in DRAIN).
    assign sample_en  = MEALY_FSM ? (state_reg == SHIFT) : prev_shift_reg;
    assign count_next = count_reg + CNT_W'(sample_en & det_match);

    seq_det_piso #(
        .LENGTH(LENGTH)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (in_data),
        .shift_en  ((state_reg == CLEAR) || (state_reg == SHIFT)),
        .cnt_en    (state_reg == SHIFT),
        .msb       (piso_msb),
        .bit_cnt   (bit_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_count_reg  <= '0;
            out_hit_reg    <= 1'b0;
            det_rst_n_reg  <= 1'b0;
            det_stream_reg <= 1'b0;
            prev_shift_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            prev_shift_reg <= (state_reg == SHIFT);
            count_reg      <= count_next;
            det_rst_n_reg  <= 1'b1;
            det_stream_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg     <= CLEAR;
                        in_ready_reg  <= 1'b0;
                        det_rst_n_reg <= 1'b0;
                        count_reg     <= '0;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end

                CLEAR: begin
                    state_reg      <= SHIFT;
                    det_stream_reg <= piso_msb;
                end

                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (MEALY_FSM) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            out_count_reg <= count_next;
                            out_hit_reg   <= (count_next != '0);
                        end else begin
                            state_reg <= DRAIN;
                        end
                    end else begin
                        det_stream_reg <= piso_msb;
                    end
                end

                DRAIN: begin
                    state_reg     <= DONE;
                    out_valid_reg <= 1'b1;
                    out_count_reg <= count_next;
                    out_hit_reg   <= (count_next != '0);
                end

                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_count  = out_count_reg;
    assign out_hit    = out_hit_reg;
    assign det_rst_n  = det_rst_n_reg;
    assign det_stream = det_stream_reg;

endmodule
